// File: rtl/vga_scanout_if.sv
// Pixel FIFO port between the frame producer's first-word-fall-through FIFO
// and the VGA scanout engine.
//
// Handshake: fifo_data is valid whenever fifo_empty is low. A rising clock
// edge with fifo_read high pops the head word. fifo_read is never raised
// while fifo_empty is high. There is no other flow control on this port.
interface vga_scanout_if;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        fifo_read;

  modport master (
    output fifo_empty,
    output fifo_data,
    input  fifo_read
  );

  modport slave (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA timing generator and RGB565 pixel scanout fed from a FWFT pixel FIFO.
// Sync, colour, trigger and underflow are all registered with one clock of latency.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic         clk,
  input  logic         reset,
  vga_scanout_if.slave fifo,
  output logic         trigger,
  output logic         hsync,
  output logic         vsync,
  output logic [4:0]   red,
  output logic [5:0]   green,
  output logic [4:0]   blue,
  output logic         underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          active;
  logic          line_end;
  logic          hsync_zone;
  logic          vsync_zone;
  logic          frame_mark;
  logic          pixel_read;
  logic          pixel_miss;

  always_comb begin
    active     = (hcount < H_ACT) && (vcount < V_ACT);
    line_end   = (hcount == H_LAST);
    hsync_zone = (hcount >= HS_FIRST) && (hcount <= HS_LAST);
    vsync_zone = (vcount >= VS_FIRST) && (vcount <= VS_LAST);
    // First blanking line start: the producer gets the whole vertical blank to refill.
    frame_mark = (hcount == '0) && (vcount == V_ACT);
    pixel_read = active && !fifo.fifo_empty && !reset;
    pixel_miss = active && fifo.fifo_empty;
  end

  assign fifo.fifo_read = pixel_read;

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (line_end) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  // A missed slot outputs black and is not retried; the next slot pops the next word.
  always_ff @(posedge clk) begin
    if (reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      trigger   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pixel_read) begin
        {red, green, blue} <= fifo.fifo_data;
      end else begin
        {red, green, blue} <= 16'h0000;
      end
      hsync     <= !hsync_zone;
      vsync     <= !vsync_zone;
      trigger   <= frame_mark;
      underflow <= underflow || pixel_miss;
    end
  end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, meaning horizontal front porch/sync/back porch in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, meaning vertical front porch/sync/back porch in lines.
REQ-005 SHALL have port clk  input  1  pixel clock; one clock domain, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port fifo_empty  input  1  pixel FIFO has no data.
REQ-008 SHALL have port fifo_data  input  16  FIFO head word, RGB565 {r[15:11],g[10:5],b[4:0]}, first-word-fall-through (valid while !fifo_empty).
REQ-009 SHALL have port fifo_read  output  1  pop FIFO head this cycle.
REQ-010 SHALL have port trigger  output  1  one-cycle frame-start pulse to the pixel producer.
REQ-011 SHALL have ports hsync, vsync  output  1 each  active-low sync.
REQ-012 SHALL have ports red 5, green 6, blue 5  output  pixel colour.
REQ-013 SHALL have port underflow  output  1  sticky: active pixel requested with FIFO empty.

Function
REQ-014 SHALL keep hcount 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800), incrementing every clock, wrapping to 0.
REQ-015 SHALL keep vcount 0..V_TOTAL-1 (525), incrementing when hcount wraps, itself wrapping 799/524 -> 0/0 in one cycle.
REQ-016 SHALL define active = hcount<H_ACTIVE && vcount<V_ACTIVE.
REQ-017 SHALL assert fifo_read combinationally = active && !fifo_empty; never when fifo_empty.
REQ-018 SHALL register pixel outputs: cycle after an active count with FIFO data, {red,green,blue} = fifo_data sampled that cycle.
REQ-019 SHALL drive {red,green,blue}=0 the cycle after any non-active count, and the cycle after an active count with fifo_empty.
REQ-020 SHALL register hsync low the cycle after hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751), else high.
REQ-021 SHALL register vsync low the cycle after vcount in [490, 491], else high; sync and colour share the same 1-cycle latency.
REQ-022 SHALL register trigger high for exactly one cycle, the cycle after hcount==0 && vcount==V_ACTIVE (start of first blanking line), once per frame.
REQ-023 SHALL set underflow the cycle after active && fifo_empty; it stays set until reset; a missed pixel is not retried (next slot reads next word).
REQ-024 SHALL never pop during blanking, so the FIFO may fill during blanking; backpressure to the producer is via FIFO full only.
REQ-025 SHALL treat fifo_data as don't-care when fifo_empty (no X propagation to colour outputs).

Reset
REQ-026 SHALL, while reset is high at a clock edge, set hcount=0, vcount=0, hsync=1, vsync=1, red/green/blue=0, trigger=0, underflow=0.
REQ-027 SHALL hold fifo_read=0 while reset is high.
REQ-028 SHALL, when reset is applied mid-line or mid-frame, abandon the frame and restart at (0,0) on the first cycle after reset deasserts; the first trigger follows after V_ACTIVE lines.

Verification
REQ-029 SHALL cover: reset then free-run 2 frames -> hsync period 800 clocks, low 96 clocks starting 657 clocks after line start; vsync period 420000 clocks, low 1600 clocks.
REQ-030 SHALL cover: FIFO model never empty, data = incrementing 16-bit counter -> exactly 307200 fifo_read per frame; pixel (x,y) colour = word y*640+x; zero colour in blanking; underflow stays 0.
REQ-031 SHALL cover: fifo_empty forced high for line 10 pixels 100..103 -> fifo_read low there, colour 0 for those 4 outputs, underflow=1 from next cycle and held across frames.
REQ-032 SHALL cover: trigger count over 3 frames -> exactly 3 one-cycle pulses, each 384000 clocks after frame start (480*800), spaced 420000 clocks.
REQ-033 SHALL cover: reset asserted at (hcount 300, vcount 200) for 3 cycles -> outputs at reset values, then hcount/vcount restart at 0, underflow cleared, next trigger 384001 clocks after deassert.
REQ-034 SHALL cover: fifo_data = 16'hF800 constant -> red=31, green=0, blue=0 on every active output.
